// File: rtl/counter_n_prog.sv
// Parametrised programmable up/down counter with wrap, saturate and one-shot modes.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module counter_n_prog #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_VAL    = (2 ** WIDTH) - 1,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  clear_flags,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  overflow,
    output logic                  running
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Elaboration-time parameter sanity checks.
    if (MAX_VAL < 1) begin : g_bad_max_lo
        $error("counter_n_prog: MAX_VAL must be at least 1");
    end
    if (WIDTH < 32 && MAX_VAL > (2 ** WIDTH) - 1) begin : g_bad_max_hi
        $error("counter_n_prog: MAX_VAL does not fit in WIDTH bits");
    end
    if (PRESCALE_W < 1) begin : g_bad_prescale
        $error("counter_n_prog: PRESCALE_W must be at least 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             overflow_q, overflow_d;
    logic             running_q, running_d;
    logic             tick_c;

    logic [WIDTH-1:0] term_c;
    logic [WIDTH-1:0] stepped_c;
    logic [WIDTH-1:0] load_clamped_c;
    logic             at_term_c;

    assign term_c         = up ? MAX_C : '0;
    assign at_term_c      = (count_q == term_c);
    assign stepped_c      = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    assign load_clamped_c = (load_value > MAX_C) ? MAX_C : load_value;

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] acc_q, acc_d;

    // Accumulator advances only on enabled cycles in RUN; ticks on match then clears.
    always_comb begin
        acc_d  = acc_q;
        tick_c = 1'b0;
        if (load) begin
            acc_d = '0;
        end else if (enable && state_q == RUN) begin
            if (acc_q == prescale) begin
                acc_d  = '0;
                tick_c = 1'b1;
            end else begin
                acc_d = acc_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign tick_c = 1'b1;
`endif

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            count_q    <= '0;
            tc_q       <= 1'b0;
            overflow_q <= 1'b0;
            running_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tc_q       <= tc_d;
            overflow_q <= overflow_d;
            running_q  <= running_d;
        end
    end

    // Next-state and next-output logic; load outranks any step.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        tc_d       = 1'b0;
        overflow_d = overflow_q & ~clear_flags;

        if (load) begin
            count_d = load_clamped_c;
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (enable && tick_c) begin
                        if (mode == MODE_SAT) begin
                            tc_d = at_term_c;
                            if (!at_term_c) begin
                                count_d = stepped_c;
                            end
                        end else if (mode == MODE_ONESHOT) begin
                            if (at_term_c) begin
                                tc_d    = 1'b1;
                                state_d = DONE;
                            end else begin
                                count_d = stepped_c;
                                if (stepped_c == term_c) begin
                                    tc_d    = 1'b1;
                                    state_d = DONE;
                                end
                            end
                        end else begin
                            // Wrap goes to the opposite end of 0..MAX_VAL, not the natural rollover.
                            if (at_term_c) begin
                                count_d    = up ? '0 : MAX_C;
                                tc_d       = 1'b1;
                                overflow_d = 1'b1;
                            end else begin
                                count_d = stepped_c;
                            end
                        end
                    end
                end
                DONE: begin
                    if (mode != MODE_ONESHOT) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        running_d = (state_d == RUN);
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign overflow = overflow_q;
    assign running  = running_q;

`ifndef SYNTHESIS
    a_count_range: assert property (@(posedge clock) disable iff (reset) count_q <= MAX_C);
    a_running_state: assert property (@(posedge clock) disable iff (reset)
        running_q == (state_q == RUN));
`endif

endmodule
